// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmit types, constants and tick-counter sizing.
package uart_pkg;
    localparam int UART_DATA_W = 8;
    localparam logic TXD_IDLE = 1'b1;
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;
    function automatic int tick_cnt_w(input int os);
        return (os > 1) ? $clog2(os) : 1;
    endfunction
endpackage

// File: rtl/uart_tx_hold.sv
// uart_tx_hold: one-entry valid/ready holding register between producer and shifter.
module uart_tx_hold
    import uart_pkg::*;
(
    input  logic                   CLOCK_50M,
    input  logic                   RST_n,
    input  logic                   push,
    input  logic [UART_DATA_W-1:0] push_data,
    input  logic                   pop,
    output logic                   ready,
    output logic                   valid,
    output logic [UART_DATA_W-1:0] data
);
    logic                   valid_q, valid_d;
    logic [UART_DATA_W-1:0] data_q, data_d;
    logic                   take;

    always_comb begin
        take    = push && !valid_q;
        valid_d = take ? 1'b1 : pop ? 1'b0 : valid_q;
        data_d  = take ? push_data : data_q;
    end

    always_ff @(posedge CLOCK_50M or negedge RST_n) begin
        if (!RST_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign ready = !valid_q;
    assign valid = valid_q;
    assign data  = data_q;
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: UART transmit sequencer gating a baud-tick generator and serialising bytes LSB-first.
// Define UART_TX_PARITY_EN to add an even-parity bit after the data bits.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                   CLOCK_50M,
    input  logic                   RST_n,
    input  logic                   tx_valid,
    input  logic [UART_DATA_W-1:0] tx_data,
    output logic                   tx_ready,
    output logic                   baud_en,
    input  logic                   baud_tick,
    output logic                   TXD,
    output logic                   tx_busy,
    output logic                   tx_done
);
    localparam int TW = tick_cnt_w(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    tx_state_e              state_q, state_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [2:0]             bit_q, bit_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   txd_q, txd_d;
    logic                   done_q, done_d;
    logic                   baud_en_q, baud_en_d;
    logic                   hold_valid, pop, adv, last_stop;
    logic [UART_DATA_W-1:0] hold_data;
`ifdef UART_TX_PARITY_EN
    logic                   par_q, par_d;
`endif

    uart_tx_hold u_hold (
        .CLOCK_50M (CLOCK_50M),
        .RST_n     (RST_n),
        .push      (tx_valid),
        .push_data (tx_data),
        .pop       (pop),
        .ready     (tx_ready),
        .valid     (hold_valid),
        .data      (hold_data)
    );

    always_comb begin
        adv       = state_q != ST_IDLE && baud_tick && tick_q == TICK_LAST;
        last_stop = state_q == ST_STOP && bit_q == STOP_LAST;
        pop       = hold_valid && (state_q == ST_IDLE || (adv && last_stop));
        state_d   = state_q;
        tick_d    = (state_q != ST_IDLE && baud_tick) ? (adv ? '0 : tick_q + TW'(1)) : tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        done_d    = adv && last_stop;
        baud_en_d = hold_valid || state_q != ST_IDLE;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            ST_START: if (adv) begin
                state_d = ST_DATA;
                txd_d   = shift_q[0];
            end
            ST_DATA: if (adv) begin
                if (bit_q == 3'd7) begin
                    bit_d = '0;
`ifdef UART_TX_PARITY_EN
                    state_d = ST_PARITY;
                    txd_d   = par_q;
`else
                    state_d = ST_STOP;
                    txd_d   = TXD_IDLE;
`endif
                end else begin
                    bit_d   = bit_q + 3'd1;
                    shift_d = shift_q >> 1;
                    txd_d   = shift_q[1];
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: if (adv) begin
                state_d = ST_STOP;
                txd_d   = TXD_IDLE;
            end
`endif
            ST_STOP: if (adv) begin
                state_d = last_stop ? ST_IDLE : ST_STOP;
                bit_d   = last_stop ? 3'd0 : bit_q + 3'd1;
            end
            default: ;
        endcase
        // A pending byte always wins: from IDLE or straight out of the final stop bit.
        if (pop) begin
            state_d = ST_START;
            shift_d = hold_data;
            txd_d   = 1'b0;
            tick_d  = '0;
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            par_d   = ^hold_data;
`endif
        end
    end

    always_ff @(posedge CLOCK_50M or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= ST_IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            txd_q     <= TXD_IDLE;
            done_q    <= 1'b0;
            baud_en_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            done_q    <= done_d;
            baud_en_q <= baud_en_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign TXD     = txd_q;
    assign tx_done = done_q;
    assign baud_en = baud_en_q;
    assign tx_busy = state_q != ST_IDLE;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: scoreboard bench for uart_tx_sched; TXD frames decoded and matched against accepted bytes.
module tb_uart_tx_sched;
`ifdef UART_TX_PARITY_EN
    localparam int SB = 2;
    localparam int PB = 1;
`else
    localparam int SB = 1;
    localparam int PB = 0;
`endif
    localparam int BIT_CLK   = 64;
    localparam int FRAME_CLK = (10 + PB + SB - 1) * BIT_CLK;
    localparam int BUDGET    = 20000;

    logic       CLOCK_50M = 0, RST_n = 0, tx_valid = 0, baud_tick = 0;
    logic [7:0] tx_data = 0;
    logic       tx_ready, baud_en, TXD, tx_busy, tx_done;
    int         tests = 0, fails = 0, done_cnt = 0, tc = 0;
    logic [7:0] sb[$];

    uart_tx_sched #(.OVERSAMPLE(16), .STOP_BITS(SB)) dut (
        .CLOCK_50M (CLOCK_50M),
        .RST_n     (RST_n),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .baud_en   (baud_en),
        .baud_tick (baud_tick),
        .TXD       (TXD),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    always #10 CLOCK_50M = ~CLOCK_50M;

    initial forever begin
        @(negedge CLOCK_50M);
        tc++;
        baud_tick = (tc % 4 == 0);
    end

    always @(negedge CLOCK_50M) if (tx_done === 1'b1) done_cnt++;

    task automatic mwait(input int n, output bit ab);
        ab = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLOCK_50M);
            if (!RST_n) begin
                ab = 1;
                break;
            end
        end
    endtask

    // Frame decoder: samples each bit near its middle and checks against the scoreboard head.
    initial begin
        bit ab, have;
        logic [7:0] rx, exp_b;
        forever begin
            @(negedge CLOCK_50M);
            if (RST_n && TXD === 1'b0) begin
                have  = sb.size() > 0;
                exp_b = have ? sb.pop_front() : 8'h00;
                tests++;
                if (!have) begin
                    fails++;
                    $display("FAIL frame_unexpected: start bit seen with empty scoreboard");
                end
                mwait(31, ab);
                if (!ab) begin
                    tests++;
                    if (TXD !== 1'b0) begin
                        fails++;
                        $display("FAIL start_bit: got %b want 0", TXD);
                    end
                end
                for (int i = 0; i < 8; i++) if (!ab) begin
                    mwait(BIT_CLK, ab);
                    rx[i] = TXD;
                end
                if (!ab && have) begin
                    tests++;
                    if (rx !== exp_b) begin
                        fails++;
                        $display("FAIL frame_data: got %h want %h", rx, exp_b);
                    end
                end
                if (PB == 1 && !ab) begin
                    mwait(BIT_CLK, ab);
                    if (!ab) begin
                        tests++;
                        if (TXD !== ^exp_b) begin
                            fails++;
                            $display("FAIL parity_bit: got %b want %b", TXD, ^exp_b);
                        end
                    end
                end
                for (int s = 0; s < SB; s++) if (!ab) begin
                    mwait(BIT_CLK, ab);
                    if (!ab) begin
                        tests++;
                        if (TXD !== 1'b1) begin
                            fails++;
                            $display("FAIL stop_bit%0d: got %b want 1", s, TXD);
                        end
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, output int waited, output logic done_at);
        waited   = 0;
        tx_valid = 1;
        tx_data  = d;
        while (!tx_ready && waited < BUDGET) begin
            @(negedge CLOCK_50M);
            waited++;
        end
        done_at = tx_done;
        if (!tx_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: tx_ready got %b want 1", tx_ready);
        end else sb.push_back(d);
        @(negedge CLOCK_50M);
        tx_valid = 0;
        tx_data  = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((tx_busy || !tx_ready || baud_en) && n < BUDGET) begin
            @(negedge CLOCK_50M);
            n++;
        end
        repeat (100) @(negedge CLOCK_50M);
        tests++;
        if (n >= BUDGET || sb.size() != 0) begin
            fails++;
            $display("FAIL idle: timeout=%0d pending=%0d want 0,0", n >= BUDGET, sb.size());
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (tx_done !== 1'b1 && n < BUDGET) begin
            @(negedge CLOCK_50M);
            n++;
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        RST_n = 0;
        repeat (3) @(negedge CLOCK_50M);
        tests += 5;
        if (TXD !== 1'b1) begin fails++; $display("FAIL rst_txd: got %b want 1", TXD); end
        if (tx_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", tx_ready); end
        if (baud_en !== 1'b0) begin fails++; $display("FAIL rst_baud_en: got %b want 0", baud_en); end
        if (tx_busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", tx_busy); end
        if (tx_done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b want 0", tx_done); end
        RST_n = 1;
        repeat (1000) begin
            @(negedge CLOCK_50M);
            if (TXD !== 1'b1 || tx_ready !== 1'b1 || baud_en !== 1'b0 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL idle_quiet: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_single();
        int w, n, base;
        logic da;
        base = done_cnt;
        send(8'hA5, w, da);
        n = 0;
        while (!tx_busy && n < BUDGET) begin @(negedge CLOCK_50M); n++; end
        wait_done(n);
        tests++;
        if (n < FRAME_CLK - 3 || n > FRAME_CLK) begin
            fails++;
            $display("FAIL single_len: got %0d clocks want %0d..%0d", n, FRAME_CLK - 3, FRAME_CLK);
        end
        tests += 2;
        if (tx_busy !== 1'b0) begin fails++; $display("FAIL single_idle_at_done: busy got %b want 0", tx_busy); end
        if (baud_en !== 1'b1) begin fails++; $display("FAIL single_baud_en_hold: got %b want 1", baud_en); end
        @(negedge CLOCK_50M);
        tests += 2;
        if (tx_done !== 1'b0) begin fails++; $display("FAIL single_done_width: got %b want 0", tx_done); end
        if (baud_en !== 1'b0) begin fails++; $display("FAIL single_baud_en_fall: got %b want 0", baud_en); end
        wait_idle();
        tests++;
        if (done_cnt - base != 1) begin fails++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt - base); end
    endtask

    task automatic test_back_to_back();
        int w, n, base;
        logic da;
        base = done_cnt;
        send(8'h00, w, da);
        send(8'hFF, w, da);
        tests++;
        if (tx_busy !== 1'b1) begin fails++; $display("FAIL b2b_accept_in_flight: busy got %b want 1", tx_busy); end
        wait_done(n);
        tests++;
        if (tx_busy !== 1'b1) begin fails++; $display("FAIL b2b_no_idle: busy got %b want 1", tx_busy); end
        @(negedge CLOCK_50M);
        wait_done(n);
        n++;
        tests++;
        if (n != FRAME_CLK) begin fails++; $display("FAIL b2b_gap: got %0d clocks want %0d", n, FRAME_CLK); end
        wait_idle();
        tests++;
        if (done_cnt - base != 2) begin fails++; $display("FAIL b2b_done_cnt: got %0d want 2", done_cnt - base); end
    endtask

    task automatic test_backpressure();
        int w;
        logic da;
        send(8'h11, w, da);
        send(8'h22, w, da);
        send(8'h33, w, da);
        tests += 2;
        if (w < FRAME_CLK - 2 * BIT_CLK) begin fails++; $display("FAIL bp_held: got %0d clocks want >= %0d", w, FRAME_CLK - 2 * BIT_CLK); end
        if (da !== 1'b1) begin fails++; $display("FAIL bp_release_at_done: tx_done got %b want 1", da); end
        wait_idle();
    endtask

    task automatic test_reset_mid_frame();
        int w, n, bad;
        logic da;
        send(8'h3C, w, da);
        n = 0;
        while (!tx_busy && n < BUDGET) begin @(negedge CLOCK_50M); n++; end
        repeat (4 * BIT_CLK + 16) @(negedge CLOCK_50M);
        RST_n = 0;
        #1;
        tests += 4;
        if (TXD !== 1'b1) begin fails++; $display("FAIL rstmid_txd: got %b want 1", TXD); end
        if (tx_busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b want 0", tx_busy); end
        if (tx_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready: got %b want 1", tx_ready); end
        if (baud_en !== 1'b0) begin fails++; $display("FAIL rstmid_baud_en: got %b want 0", baud_en); end
        sb.delete();
        repeat (3) @(negedge CLOCK_50M);
        RST_n = 1;
        bad = 0;
        repeat (2000) begin
            @(negedge CLOCK_50M);
            if (TXD !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1) bad++;
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL rstmid_residual: got %0d bad cycles want 0", bad); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int w, n;
        logic da;
        logic [7:0] vals [2] = '{8'h07, 8'h03};
        logic       pars [2] = '{1'b1, 1'b0};
        for (int k = 0; k < 2; k++) begin
            send(vals[k], w, da);
            n = 0;
            while (!tx_busy && n < BUDGET) begin @(negedge CLOCK_50M); n++; end
            repeat (9 * BIT_CLK + 30) @(negedge CLOCK_50M);
            tests++;
            if (TXD !== pars[k]) begin fails++; $display("FAIL parity_%h: got %b want %b", vals[k], TXD, pars[k]); end
            repeat (BIT_CLK) @(negedge CLOCK_50M);
            tests++;
            if (TXD !== 1'b1) begin fails++; $display("FAIL parity_stop_%h: got %b want 1", vals[k], TXD); end
            wait_idle();
        end
    endtask
`endif

    initial begin
        test_reset();
        @(negedge CLOCK_50M);
        test_single();
        test_back_to_back();
        test_backpressure();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
